// File: rtl/spi_reg_controller_pkg.sv
// Shared definitions for the SPI register-bus command sequencer.
//   state_t         : sequencer states
//   RW_BIT          : command byte bit selecting read (1) or write (0)
//   STATUS_BYTE_DEF : default byte returned while the command byte shifts in
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      WR_WAIT = 3'd2,
      WR_BUS  = 3'd3,
      RD_REQ  = 3'd4,
      RD_HOLD = 3'd5,
      DRAIN   = 3'd6
   } state_t;

   localparam int         RW_BIT          = 7;
   localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_reg_controller_if.sv
// Signal bundle between the command sequencer, the SPI byte shifter and the
// register bus.
//   master : sequencer side (drives tx staging, bus strobes, error flags, busy)
//   slave  : shifter / register-bus side
interface spi_reg_controller_if #(
   parameter int ADDR_W = 7
);
   logic              frame_active;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ack;
   logic [ADDR_W-1:0] bus_addr;
   logic [7:0]        bus_wdata;
   logic              bus_we;
   logic              bus_re;
   logic [7:0]        bus_rdata;
   logic              bus_ready;
   logic              err_overrun;
   logic              err_underrun;
   logic              busy;

   modport master (
      input  frame_active, rx_valid, rx_data, tx_ack, bus_rdata, bus_ready,
      output tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re,
             err_overrun, err_underrun, busy
   );

   modport slave (
      output frame_active, rx_valid, rx_data, tx_ack, bus_rdata, bus_ready,
      input  tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re,
             err_overrun, err_underrun, busy
   );
endinterface

// File: rtl/spi_reg_controller.sv
// Command sequencer between the SPI byte shifter and the register bus.
// The first byte of each chip-select frame is a command (bit 7 = read,
// low bits = address); following bytes stream to/from the register bus with
// optional address auto-increment.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active high
//   io  : spi_reg_controller_if.master (shifter handshake, register bus,
//         sticky error flags, busy)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame; waiting for a chip-select rising edge
// CMD     | status byte staged; waiting for the command byte
// WR_WAIT | write stream; waiting for the next data byte
// WR_BUS  | bus_we high until bus_ready; extra rx bytes are overruns
// RD_REQ  | bus_re high until bus_ready (prefetch of the next tx byte)
// RD_HOLD | read byte staged on tx; waiting for the shifter to take it
// DRAIN   | frame ended with a strobe pending; finish it, then IDLE
module spi_reg_controller
   import spi_ctrl_pkg::*;
#(
   parameter int         ADDR_W      = 7,
   parameter bit         AUTO_INC    = 1'b1,
   parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_reg_controller_if.master  io
);

   state_t            state_q, state_d;
   logic              frame_q;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
   logic              rw_q, rw_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic              ovr_q, ovr_d;
   logic              und_q, und_d;
   logic              strobe;

   assign addr_inc = AUTO_INC ? addr_q + ADDR_W'(1) : addr_q;

   // Strobes are mutually exclusive, so the latched direction picks the live one.
   assign strobe = rw_q ? re_q : we_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         frame_q    <= 1'b0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         wdata_q    <= 8'h00;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         ovr_q      <= 1'b0;
         und_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= io.frame_active;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         re_q       <= re_d;
         ovr_q      <= ovr_d;
         und_q      <= und_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      re_d       = re_q;
      ovr_d      = ovr_q;
      und_d      = und_q;

      if (state_q != IDLE && state_q != DRAIN && !io.frame_active) begin
         // Frame end outranks rx_valid and tx_ack arriving in the same cycle.
         tx_valid_d = 1'b0;
         if (strobe && !io.bus_ready) begin
            state_d = DRAIN;
         end else begin
            state_d = IDLE;
            we_d    = 1'b0;
            re_d    = 1'b0;
         end
      end else begin
         if (io.tx_ack) tx_valid_d = 1'b0;

         case (state_q)
            IDLE: begin
               if (io.frame_active && !frame_q) begin
                  state_d    = CMD;
                  tx_data_d  = STATUS_BYTE;
                  tx_valid_d = 1'b1;
                  ovr_d      = 1'b0;
                  und_d      = 1'b0;
               end
            end
            CMD: begin
               if (io.rx_valid) begin
                  rw_d   = io.rx_data[RW_BIT];
                  addr_d = io.rx_data[ADDR_W-1:0];
                  if (io.rx_data[RW_BIT]) begin
                     state_d = RD_REQ;
                     re_d    = 1'b1;
                  end else begin
                     state_d   = WR_WAIT;
                     tx_data_d = 8'h00;
                  end
               end
            end
            WR_WAIT: begin
               if (io.rx_valid) begin
                  wdata_d = io.rx_data;
                  we_d    = 1'b1;
                  state_d = WR_BUS;
               end
            end
            WR_BUS: begin
               if (io.rx_valid) ovr_d = 1'b1;
               if (io.bus_ready) begin
                  we_d    = 1'b0;
                  addr_d  = addr_inc;
                  state_d = WR_WAIT;
               end
            end
            RD_REQ: begin
               // Shifter reloaded before the prefetch landed; it sends its default.
               if (io.tx_ack && !tx_valid_q) und_d = 1'b1;
               if (io.bus_ready) begin
                  tx_data_d  = io.bus_rdata;
                  tx_valid_d = 1'b1;
                  re_d       = 1'b0;
                  state_d    = RD_HOLD;
               end
            end
            RD_HOLD: begin
               if (io.tx_ack) begin
                  addr_d  = addr_inc;
                  re_d    = 1'b1;
                  state_d = RD_REQ;
               end
            end
            DRAIN: begin
               if (io.bus_ready) begin
                  we_d    = 1'b0;
                  re_d    = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign io.tx_data      = tx_data_q;
   assign io.tx_valid     = tx_valid_q;
   assign io.bus_addr     = addr_q;
   assign io.bus_wdata    = wdata_q;
   assign io.bus_we       = we_q;
   assign io.bus_re       = re_q;
   assign io.err_overrun  = ovr_q;
   assign io.err_underrun = und_q;
   assign io.busy         = (state_q != IDLE);

endmodule
